// File: rtl/reg_bank_sb_if.sv
// reg_bank_sb_if: read/write/issue bus of the scoreboarded register bank
interface reg_bank_sb_if #(
  parameter int XLEN = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);
  logic [AW:0] selA;
  logic [AW-1:0] selB;
  logic [XLEN-1:0] inPC;
  logic we0;
  logic [AW-1:0] rd0;
  logic [XLEN-1:0] busC0;
  logic we1;
  logic [AW-1:0] rd1;
  logic [XLEN-1:0] busC1;
  logic iss_valid;
  logic [AW-1:0] iss_rd;
  logic [XLEN-1:0] outA;
  logic [XLEN-1:0] outB;
  logic busyA;
  logic busyB;
  logic [AW:0] pend_count;
  modport master (
    output selA, selB, inPC, we0, rd0, busC0, we1, rd1, busC1, iss_valid, iss_rd,
    input outA, outB, busyA, busyB, pend_count
  );
  modport slave (
    input selA, selB, inPC, we0, rd0, busC0, we1, rd1, busC1, iss_valid, iss_rd,
    output outA, outB, busyA, busyB, pend_count
  );
endinterface

// File: rtl/reg_bank_sb.sv
// reg_bank_sb: two-write-port register bank with optional bypass and a load scoreboard
module reg_bank_sb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter bit BYPASS = 1'b1
) (
  input logic clk,
  input logic reset,
  reg_bank_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, busy_nxt, set_m, clr_m;
  logic [AW:0] pend;
  logic [AW-1:0] sa, rd0, rd1;
  logic pc_sel, we0, we1;
  logic [XLEN-1:0] c0, c1;
  assign sa = bus.selA[AW-1:0];
  assign pc_sel = bus.selA[AW];
  assign we0 = bus.we0;
  assign we1 = bus.we1;
  assign rd0 = bus.rd0;
  assign rd1 = bus.rd1;
  assign c0 = bus.busC0;
  assign c1 = bus.busC1;
  // clear before set so an issue and a retire on the same index leave it busy
  always_comb begin
    set_m = '0;
    clr_m = '0;
    set_m[bus.iss_rd] = bus.iss_valid && bus.iss_rd != '0;
    clr_m[rd1] = we1;
    busy_nxt = (busy & ~clr_m) | set_m;
  end
  always_ff @(negedge clk or negedge reset)
    if (!reset) begin
      busy <= '0;
      pend <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      busy <= busy_nxt;
      pend <= (AW+1)'($countones(busy_nxt));
      for (int i = 1; i < NREGS; i++)
        if (we0 && rd0 == AW'(i)) regs[i] <= c0;
        else if (we1 && rd1 == AW'(i)) regs[i] <= c1;
    end
  function automatic logic [XLEN-1:0] rd_val(input logic [AW-1:0] s);
    return s == '0 ? '0 :
           BYPASS && we0 && rd0 == s ? c0 :
           BYPASS && we1 && rd1 == s ? c1 : regs[s];
  endfunction
  // a resolving load no longer stalls the reader when its data is being forwarded
  function automatic logic rd_busy(input logic [AW-1:0] s);
    return busy[s] && !(BYPASS && we1 && rd1 == s);
  endfunction
  assign bus.outA = pc_sel ? bus.inPC : rd_val(sa);
  assign bus.busyA = !pc_sel && rd_busy(sa);
  assign bus.outB = rd_val(bus.selB);
  assign bus.busyB = rd_busy(bus.selB);
  assign bus.pend_count = pend;
endmodule
